pipeline_stall_controller: RTL and testbench

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipeline_stall_controller.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Hazard and stall controller for a five-stage in-order pipeline. It handles
// three situations:
//   * Data-memory miss: the whole pipeline freezes in RUN, and then in MEM_WAIT,
//     until memory reports ready.
//   * Load-use hazard: PC and IF/ID hold, and a bubble is inserted into ID/EX.
//   * Taken branch: IF/ID is cleared, but only in cycles where IF/ID is
//     actually written.
//
// Priority is memory miss > load-use > branch.
//
// A taken branch that is parked in ID during a stall is flushed in the first
// cycle the stall releases. This falls out of gating IF_Flush_o with
// IF_ID_Write_o.
//
// Optional feature (macro STALL_PERF_COUNTER_EN):
//   defined   : Stall_Count_o counts clock edges where PCWrite_o=0
//               (saturating).
//   undefined : Stall_Count_o is tied to zero and no counter register exists.
//
// Ports
//   clk_i               in   pipeline clock, rising edge
//   rst_i               in   asynchronous reset, active-low
//   ID_EX_MemRead_i     in   instruction in EX is a load
//   IF_ID_RegisterRs1_i in   rs1 of the instruction in ID
//   IF_ID_RegisterRs2_i in   rs2 of the instruction in ID
//   ID_EX_RegisterRd_i  in   rd of the instruction in EX
//   Branch_Taken_i      in   branch in ID resolved taken
//   DMem_Req_i          in   MEM stage issues a data-memory access
//   DMem_Ready_i        in   data memory completed the access
//   PCWrite_o           out  PC update enable
//   IF_ID_Write_o       out  IF/ID write enable
//   ID_EX_Write_o       out  ID/EX write enable
//   EX_MEM_Write_o      out  EX/MEM write enable
//   Flush_o             out  bubble (zeroed control) into ID/EX
//   IF_Flush_o          out  clear IF/ID to a NOP
//   Mem_Timeout_o       out  sticky: a memory wait hit the 255-cycle limit
//   Stall_Count_o       out  stall cycle count (0 unless STALL_PERF_COUNTER_EN)
// ---------------------------------------------------------------------------
module pipeline_stall_controller (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ID_EX_MemRead_i,
    input  logic [4:0]  IF_ID_RegisterRs1_i,
    input  logic [4:0]  IF_ID_RegisterRs2_i,
    input  logic [4:0]  ID_EX_RegisterRd_i,
    input  logic        Branch_Taken_i,
    input  logic        DMem_Req_i,
    input  logic        DMem_Ready_i,
    output logic        PCWrite_o,
    output logic        IF_ID_Write_o,
    output logic        ID_EX_Write_o,
    output logic        EX_MEM_Write_o,
    output logic        Flush_o,
    output logic        IF_Flush_o,
    output logic        Mem_Timeout_o,
    output logic [31:0] Stall_Count_o
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       timeout_q;
    logic       load_use;
    logic       mem_miss;
    logic       timeout_now;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign load_use = ID_EX_MemRead_i
                    && (ID_EX_RegisterRd_i != 5'd0)
                    && ((ID_EX_RegisterRd_i == IF_ID_RegisterRs1_i)
                        || (ID_EX_RegisterRd_i == IF_ID_RegisterRs2_i));

    assign mem_miss = DMem_Req_i && !DMem_Ready_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and enable generation
    always_comb begin
        state_next     = state;
        PCWrite_o      = 1'b0;
        IF_ID_Write_o  = 1'b0;
        ID_EX_Write_o  = 1'b0;
        EX_MEM_Write_o = 1'b0;
        Flush_o        = 1'b0;

        // While reset is held, every enable stays at its zero default.
        if (rst_i) begin
            case (state)
                RUN: begin
                    if (mem_miss) begin
                        // Full freeze starts in the miss cycle itself.
                        state_next = MEM_WAIT;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, and let EX/MEM drain.
                        ID_EX_Write_o  = 1'b1;
                        EX_MEM_Write_o = 1'b1;
                        Flush_o        = 1'b1;
                    end else begin
                        PCWrite_o      = 1'b1;
                        IF_ID_Write_o  = 1'b1;
                        ID_EX_Write_o  = 1'b1;
                        EX_MEM_Write_o = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Ready releases unconditionally. Any new miss presented in
                    // the release cycle is picked up from RUN on the next cycle.
                    if (DMem_Ready_i) begin
                        PCWrite_o      = 1'b1;
                        IF_ID_Write_o  = 1'b1;
                        ID_EX_Write_o  = 1'b1;
                        EX_MEM_Write_o = 1'b1;
                        state_next     = RUN;
                    end
                end
            endcase
        end

        // A held branch is flushed as soon as IF/ID is written again.
        IF_Flush_o = IF_ID_Write_o && Branch_Taken_i;
    end

    // Wait counter: cleared on entry to MEM_WAIT, saturates at 255.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= 8'd0;
        end else if ((state == RUN) && (state_next == MEM_WAIT)) begin
            wait_cnt <= 8'd0;
        end else if ((state == MEM_WAIT) && (wait_cnt != 8'hFF)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_now = (state == MEM_WAIT) && (wait_cnt == 8'hFF) && !DMem_Ready_i;

    // Timeout flag: sticky until reset.
    // The flag reports in the same cycle the limit is reached; timeout_q then
    // holds it for all later cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            timeout_q <= 1'b0;
        end else if (timeout_now) begin
            timeout_q <= 1'b1;
        end
    end

    assign Mem_Timeout_o = timeout_q || timeout_now;

`ifdef STALL_PERF_COUNTER_EN
    logic [31:0] stall_cnt;

    // Stall counter: one count per edge with the PC held.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= 32'd0;
        end else if (!PCWrite_o && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign Stall_Count_o = stall_cnt;
`else
    assign Stall_Count_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// Directed bench for pipeline_stall_controller.
//
// How a step works:
//   * Inputs are driven 1 ns after the rising edge.
//   * The expected outputs are pushed to a scoreboard queue at the same time.
//   * On the falling edge the expectation is popped and compared with the
//     DUT outputs.
//
// Enable vectors are listed as {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
// Flush, IF_Flush}.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        ID_EX_MemRead_i = 1'b0;
    logic [4:0]  IF_ID_RegisterRs1_i = 5'd0;
    logic [4:0]  IF_ID_RegisterRs2_i = 5'd0;
    logic [4:0]  ID_EX_RegisterRd_i = 5'd0;
    logic        Branch_Taken_i = 1'b0;
    logic        DMem_Req_i = 1'b0;
    logic        DMem_Ready_i = 1'b0;
    logic        PCWrite_o;
    logic        IF_ID_Write_o;
    logic        ID_EX_Write_o;
    logic        EX_MEM_Write_o;
    logic        Flush_o;
    logic        IF_Flush_o;
    logic        Mem_Timeout_o;
    logic [31:0] Stall_Count_o;

    pipeline_stall_controller dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .ID_EX_MemRead_i     (ID_EX_MemRead_i),
        .IF_ID_RegisterRs1_i (IF_ID_RegisterRs1_i),
        .IF_ID_RegisterRs2_i (IF_ID_RegisterRs2_i),
        .ID_EX_RegisterRd_i  (ID_EX_RegisterRd_i),
        .Branch_Taken_i      (Branch_Taken_i),
        .DMem_Req_i          (DMem_Req_i),
        .DMem_Ready_i        (DMem_Ready_i),
        .PCWrite_o           (PCWrite_o),
        .IF_ID_Write_o       (IF_ID_Write_o),
        .ID_EX_Write_o       (ID_EX_Write_o),
        .EX_MEM_Write_o      (EX_MEM_Write_o),
        .Flush_o             (Flush_o),
        .IF_Flush_o          (IF_Flush_o),
        .Mem_Timeout_o       (Mem_Timeout_o),
        .Stall_Count_o       (Stall_Count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [5:0]  en;
        logic        tmo;
        logic [31:0] cnt;
    } exp_t;

    localparam logic [5:0] ALL1 = 6'b111100;   // everything advances
    localparam logic [5:0] BRF  = 6'b111101;   // advance and flush IF/ID
    localparam logic [5:0] FRZ  = 6'b000000;   // full freeze / reset
    localparam logic [5:0] LUS  = 6'b001110;   // load-use bubble

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_stalls = 32'd0;

    task automatic step(input string tag, input logic rst, input logic mr,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic br, input logic req,
                        input logic rdy, input logic [5:0] en, input logic tmo);
        exp_t       e;
        exp_t       got;
        logic [5:0] obs;
        @(posedge clk_i);
        #1;
        rst_i               = rst;
        ID_EX_MemRead_i     = mr;
        IF_ID_RegisterRs1_i = rs1;
        IF_ID_RegisterRs2_i = rs2;
        ID_EX_RegisterRd_i  = rd;
        Branch_Taken_i      = br;
        DMem_Req_i          = req;
        DMem_Ready_i        = rdy;
        if (!rst) exp_stalls = 32'd0;
        e.en  = en;
        e.tmo = tmo;
`ifdef STALL_PERF_COUNTER_EN
        e.cnt = exp_stalls;
`else
        e.cnt = 32'd0;
`endif
        sb_q.push_back(e);
        @(negedge clk_i);
        got = sb_q.pop_front();
        obs = {PCWrite_o, IF_ID_Write_o, ID_EX_Write_o, EX_MEM_Write_o, Flush_o, IF_Flush_o};
        checks++;
        assert (obs === got.en) else begin
            failures++;
            $error("FAIL %s enables observed=%b expected=%b", tag, obs, got.en);
        end
        checks++;
        assert (Mem_Timeout_o === got.tmo) else begin
            failures++;
            $error("FAIL %s timeout observed=%b expected=%b", tag, Mem_Timeout_o, got.tmo);
        end
        checks++;
        assert (Stall_Count_o === got.cnt) else begin
            failures++;
            $error("FAIL %s stall_count observed=%0d expected=%0d", tag, Stall_Count_o, got.cnt);
        end
        // The PC is held at the coming edge, so the model counts one more stall.
        if (rst && !en[5]) exp_stalls = exp_stalls + 32'd1;
    endtask

    initial begin
        // Reset state
        step("reset0", 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 0);
        step("reset1", 0, 1, 5, 5, 5, 1, 1, 0, FRZ, 0);
        step("idle",   1, 0, 0, 0, 0, 0, 0, 0, ALL1, 0);
        step("branch", 1, 0, 0, 0, 0, 1, 0, 0, BRF, 0);

        // Load-use on rs1, then clear
        step("lu_rs1",   1, 1, 5, 0, 5, 0, 0, 0, LUS, 0);
        step("lu_clear", 1, 0, 5, 0, 5, 0, 0, 0, ALL1, 0);
        // Load-use on rs2, with a taken branch held through the stall
        step("lu_rs2",     1, 1, 3, 7, 7, 1, 0, 0, LUS, 0);
        step("lu_br_rel",  1, 0, 3, 7, 7, 1, 0, 0, BRF, 0);
        // No hazard cases
        step("rd_zero",    1, 1, 0, 0, 0, 0, 0, 0, ALL1, 0);
        step("rd_nomatch", 1, 1, 3, 2, 4, 0, 0, 0, ALL1, 0);
        step("no_memread", 1, 0, 5, 5, 5, 0, 0, 0, ALL1, 0);

        // Memory wait: 3 frozen cycles, release in the 4th
        step("mw_rst",   0, 0, 0, 0, 0, 0, 0, 0, FRZ, 0);
        step("mw_miss",  1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0);
        step("mw_wait1", 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0);
        step("mw_wait2", 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0);
        step("mw_rel",   1, 0, 0, 0, 0, 0, 1, 1, ALL1, 0);
        step("mw_run",   1, 0, 0, 0, 0, 0, 0, 0, ALL1, 0);

        // Priority: MM + LU + branch -> full freeze; then the branch is flushed
        step("pr_miss", 1, 1, 5, 0, 5, 1, 1, 0, FRZ, 0);
        step("pr_wait", 1, 1, 5, 0, 5, 1, 1, 0, FRZ, 0);
        step("pr_rel",  1, 0, 5, 0, 5, 1, 0, 1, BRF, 0);
        step("pr_done", 1, 0, 5, 0, 5, 0, 0, 0, ALL1, 0);

        // Timeout: the flag appears in wait cycle 256 and stays set
        step("to_miss", 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 0);
        for (int j = 1; j <= 259; j++) begin
            step("to_wait", 1, 0, 0, 0, 0, 0, 1, 0, FRZ, (j >= 256));
        end
        step("to_rel",  1, 0, 0, 0, 0, 0, 1, 1, ALL1, 1);
        step("to_hold", 1, 0, 0, 0, 0, 1, 0, 0, BRF, 1);

        // Reset in cycle 2 of MEM_WAIT
        step("rw_miss",  1, 0, 0, 0, 0, 0, 1, 0, FRZ, 1);
        step("rw_wait1", 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 1);
        step("rw_reset", 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0);
        step("rw_run",   1, 0, 0, 0, 0, 0, 0, 0, ALL1, 0);
        step("rw_run2",  1, 1, 9, 0, 9, 0, 0, 0, LUS, 0);
        step("rw_run3",  1, 0, 0, 0, 0, 0, 0, 0, ALL1, 0);

        checks++;
        assert (sb_q.size() === 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
